// File: rtl/fft_engine_n.sv
// fft_engine_n: memory-based radix-2 DIT FFT, N = 2**LOG2N, one shared butterfly,
// bit-reversed load, in-place stages, natural-order unload.
// Optional macro FFT_STAGE_SCALE_EN: halve both butterfly outputs on every stage.
// Twiddles are derived from a 2**24-scaled sine table, valid for WIDTH <= 25.
module fft_engine_n #(
    parameter int WIDTH = 9,
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_i,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_r,
    output logic [WIDTH-1:0] out_i,
    output logic [LOG2N-1:0] out_idx,
    output logic             busy
);
    localparam int N  = 1 << LOG2N;
    localparam int H  = N / 2;
    localparam int SW = $clog2(LOG2N);
    localparam int PW = 2 * WIDTH + 2;
    localparam int SH = 26 - WIDTH;
`ifdef FFT_STAGE_SCALE_EN
    localparam int SC = 1;
`else
    localparam int SC = 0;
`endif

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    // sin(m*pi/32) * 2**24 for m = 0..16
    function automatic int sin64(input int m);
        case (m)
            0:  return 0;
            1:  return 1644455;
            2:  return 3273072;
            3:  return 4870169;
            4:  return 6420363;
            5:  return 7908725;
            6:  return 9320922;
            7:  return 10643353;
            8:  return 11863283;
            9:  return 12968963;
            10: return 13949745;
            11: return 14796184;
            12: return 15500126;
            13: return 16054795;
            14: return 16454846;
            15: return 16696429;
            default: return 16777216;
        endcase
    endfunction

    // Round a 2**24-scaled value to 2**(WIDTH-2) scale, half away from zero
    function automatic int rnd(input int v);
        int a;
        a = v < 0 ? -v : v;
        a = (a + (1 << (SH - 1))) >>> SH;
        return v < 0 ? -a : a;
    endfunction

    function automatic int tw_cos(input int k);
        int m;
        m = k << (6 - LOG2N);
        return m <= 16 ? rnd(sin64(16 - m)) : -rnd(sin64(m - 16));
    endfunction

    function automatic int tw_sin(input int k);
        int m;
        m = k << (6 - LOG2N);
        return m <= 16 ? rnd(sin64(m)) : rnd(sin64(32 - m));
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) r[b] = v[LOG2N-1-b];
        return r;
    endfunction

    logic signed [WIDTH-1:0] tw_r [H];
    logic signed [WIDTH-1:0] tw_i [H];

    for (genvar k = 0; k < H; k++) begin : g_tw
        assign tw_r[k] = WIDTH'(tw_cos(k));
        assign tw_i[k] = WIDTH'(-tw_sin(k));
    end

    state_t                  state_q;
    logic [LOG2N-1:0]        cnt_q;
    logic [LOG2N-2:0]        bf_q;
    logic [SW-1:0]           stage_q;
    logic                    in_rdy_q;
    logic                    out_vld_q;
    logic                    busy_q;
    logic signed [WIDTH-1:0] mem_r_q [N];
    logic signed [WIDTH-1:0] mem_i_q [N];

    logic [LOG2N-1:0]        span, j, top, bot;
    logic [LOG2N-2:0]        tw_k;
    logic signed [WIDTH-1:0] a_r, a_i, b_r, b_i, w_r, w_i;
    logic signed [PW-1:0]    t_r, t_i;
    logic signed [WIDTH-1:0] y0_r, y0_i, y1_r, y1_i;

    // Butterfly address generation for the current stage/butterfly counters
    always_comb begin
        span = LOG2N'(1) << stage_q;
        j    = {1'b0, bf_q} & (span - 1'b1);
        top  = (({1'b0, bf_q} >> stage_q) << (int'(stage_q) + 1)) | j;
        bot  = top | span;
        tw_k = (LOG2N-1)'(j << (LOG2N - 1 - int'(stage_q)));
    end

    // Shared butterfly: complex product sums kept full width, truncated by WIDTH-2
    always_comb begin
        a_r  = mem_r_q[top];
        a_i  = mem_i_q[top];
        b_r  = mem_r_q[bot];
        b_i  = mem_i_q[bot];
        w_r  = tw_r[tw_k];
        w_i  = tw_i[tw_k];
        t_r  = (PW'(b_r) * PW'(w_r) - PW'(b_i) * PW'(w_i)) >>> (WIDTH - 2);
        t_i  = (PW'(b_r) * PW'(w_i) + PW'(b_i) * PW'(w_r)) >>> (WIDTH - 2);
        y0_r = WIDTH'((PW'(a_r) + t_r) >>> SC);
        y0_i = WIDTH'((PW'(a_i) + t_i) >>> SC);
        y1_r = WIDTH'((PW'(a_r) - t_r) >>> SC);
        y1_i = WIDTH'((PW'(a_i) - t_i) >>> SC);
    end

    // Sample storage: bit-reversed writes in LOAD, in-place write-back in COMPUTE
    always_ff @(posedge clk) begin
        if (!rstn && state_q == LOAD && in_vld) begin
            mem_r_q[bitrev(cnt_q)] <= in_r;
            mem_i_q[bitrev(cnt_q)] <= in_i;
        end else if (!rstn && state_q == COMPUTE) begin
            mem_r_q[top] <= y0_r;
            mem_i_q[top] <= y0_i;
            mem_r_q[bot] <= y1_r;
            mem_i_q[bot] <= y1_i;
        end
    end

    // Frame sequencing: LOAD -> COMPUTE -> UNLOAD with registered handshake flags
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            bf_q      <= '0;
            stage_q   <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                LOAD: if (in_vld) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LOG2N'(N - 1)) begin
                        state_q  <= COMPUTE;
                        in_rdy_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                COMPUTE: begin
                    bf_q <= bf_q + 1'b1;
                    if (bf_q == '1) begin
                        if (stage_q == SW'(LOG2N - 1)) begin
                            state_q   <= UNLOAD;
                            out_vld_q <= 1'b1;
                            stage_q   <= '0;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                        end
                    end
                end
                UNLOAD: if (out_rdy) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LOG2N'(N - 1)) begin
                        state_q   <= LOAD;
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_vld = out_vld_q;
    assign busy    = busy_q;
    assign out_r   = out_vld_q ? mem_r_q[cnt_q] : '0;
    assign out_i   = out_vld_q ? mem_i_q[cnt_q] : '0;
    assign out_idx = out_vld_q ? cnt_q : '0;
endmodule

// File: tb/tb_fft_engine_n.sv
// tb_fft_engine_n: table-driven frames with a scoreboard for N=8 and N=16 engines.
`timescale 1ns/1ps
module tb_fft_engine_n;
`ifdef FFT_STAGE_SCALE_EN
    localparam int IMP = 2, DCV = 4, ALT = 4, COSV = 32, IMP16 = 1;
`else
    localparam int IMP = 16, DCV = 32, ALT = 32, COSV = 256, IMP16 = 16;
`endif

    typedef struct {
        string name;
        int    xr[8];
        int    er[8];
        int    tol;
    } vec_t;

    typedef struct {
        int idx;
        int r;
        int i;
        int tol;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       v8 = 1'b0, ordy8 = 1'b1, rdy8, ov8, busy8;
    logic [8:0] r8 = '0, i8 = '0, or8, oi8;
    logic [2:0] idx8;
    logic       v16 = 1'b0, ordy16 = 1'b1, rdy16, ov16, busy16;
    logic [8:0] r16 = '0, i16 = '0, or16, oi16;
    logic [3:0] idx16;

    int   tests = 0;
    int   fails = 0;
    int   stim[16];
    vec_t tbl[4];
    exp_t q8[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    fft_engine_n #(.WIDTH(9), .LOG2N(3)) u_dut8 (
        .clk(clk), .rstn(rstn), .in_vld(v8), .in_rdy(rdy8), .in_r(r8), .in_i(i8),
        .out_vld(ov8), .out_rdy(ordy8), .out_r(or8), .out_i(oi8), .out_idx(idx8), .busy(busy8)
    );

    fft_engine_n #(.WIDTH(9), .LOG2N(4)) u_dut16 (
        .clk(clk), .rstn(rstn), .in_vld(v16), .in_rdy(rdy16), .in_r(r16), .in_i(i16),
        .out_vld(ov16), .out_rdy(ordy16), .out_r(or16), .out_i(oi16), .out_idx(idx16), .busy(busy16)
    );

    // Values compare modulo 2**9, so a wrapped 256 matches -256
    function automatic bit near(input int act, input int exp, input int tol);
        int d;
        d = (((act - exp) % 512) + 512) % 512;
        if (d >= 256) d -= 512;
        return d <= tol && d >= -tol;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard for the 8-point engine
    always @(negedge clk) begin
        exp_t e;
        if (ov8 && ordy8) begin
            tests++;
            if (q8.size() == 0) begin
                fails++;
                $display("FAIL out8_unexpected: idx=%0d r=%0d i=%0d", idx8, $signed(or8), $signed(oi8));
            end else begin
                e = q8.pop_front();
                if (!(int'(idx8) == e.idx && near(int'($signed(or8)), e.r, e.tol) &&
                      near(int'($signed(oi8)), e.i, e.tol) && !rdy8 && busy8)) begin
                    fails++;
                    $display("FAIL out8: got idx=%0d r=%0d i=%0d rdy=%0d busy=%0d, expected idx=%0d r=%0d i=%0d (tol %0d) rdy=0 busy=1",
                             idx8, $signed(or8), $signed(oi8), rdy8, busy8, e.idx, e.r, e.i, e.tol);
                end
            end
        end
    end

    // Scoreboard for the 16-point engine
    always @(negedge clk) begin
        exp_t e;
        if (ov16 && ordy16) begin
            tests++;
            if (q16.size() == 0) begin
                fails++;
                $display("FAIL out16_unexpected: idx=%0d r=%0d i=%0d", idx16, $signed(or16), $signed(oi16));
            end else begin
                e = q16.pop_front();
                if (!(int'(idx16) == e.idx && near(int'($signed(or16)), e.r, e.tol) &&
                      near(int'($signed(oi16)), e.i, e.tol) && !rdy16 && busy16)) begin
                    fails++;
                    $display("FAIL out16: got idx=%0d r=%0d i=%0d rdy=%0d busy=%0d, expected idx=%0d r=%0d i=%0d (tol %0d) rdy=0 busy=1",
                             idx16, $signed(or16), $signed(oi16), rdy16, busy16, e.idx, e.r, e.i, e.tol);
                end
            end
        end
    end

    // Drive n samples from stim; optionally measure accept-to-first-output latency
    task automatic send(input bit big, input int n, input int lat);
        int w;
        int l;
        for (int k = 0; k < n; k++) begin
            if (big) begin v16 = 1'b1; r16 = 9'(stim[k]); i16 = '0; end
            else begin v8 = 1'b1; r8 = 9'(stim[k]); i8 = '0; end
            w = 0;
            @(negedge clk);
            while (!(big ? rdy16 : rdy8) && w < 200) begin @(negedge clk); w++; end
            if (!(big ? rdy16 : rdy8)) chk("in_rdy_wait", 0, 1);
            @(posedge clk); #1;
        end
        v8 = 1'b0;
        v16 = 1'b0;
        if (lat > 0) begin
            l = 0;
            do begin @(posedge clk); #1; l++; end while (!(big ? ov16 : ov8) && l < 200);
            chk(big ? "latency16" : "latency8", l, lat);
        end
    endtask

    task automatic wait_done(input bit big);
        int w;
        w = 0;
        do begin @(posedge clk); #1; w++; end
        while (((big ? q16.size() : q8.size()) != 0 || !(big ? rdy16 : rdy8)) && w < 400);
        chk(big ? "drain16" : "drain8", big ? q16.size() : q8.size(), 0);
        chk(big ? "idle_rdy16" : "idle_rdy8", int'(big ? rdy16 : rdy8), 1);
        chk(big ? "idle_busy16" : "idle_busy8", int'(big ? busy16 : busy8), 0);
    endtask

    task automatic run_vec(input int t);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            stim[k] = tbl[t].xr[k];
            e.idx = k; e.r = tbl[t].er[k]; e.i = 0; e.tol = tbl[t].tol;
            q8.push_back(e);
        end
        send(1'b0, 8, 12);
        wait_done(1'b0);
    endtask

    task automatic check_idle8(input string tag);
        chk({tag, "_in_rdy"}, int'(rdy8), 1);
        chk({tag, "_out_vld"}, int'(ov8), 0);
        chk({tag, "_busy"}, int'(busy8), 0);
        chk({tag, "_out_r"}, int'(or8), 0);
        chk({tag, "_out_i"}, int'(oi8), 0);
        chk({tag, "_out_idx"}, int'(idx8), 0);
    endtask

    initial begin
        exp_t e;
        tbl[0].name = "impulse"; tbl[0].xr = '{16, 0, 0, 0, 0, 0, 0, 0};
        tbl[0].er = '{IMP, IMP, IMP, IMP, IMP, IMP, IMP, IMP}; tbl[0].tol = 0;
        tbl[1].name = "dc"; tbl[1].xr = '{4, 4, 4, 4, 4, 4, 4, 4};
        tbl[1].er = '{DCV, 0, 0, 0, 0, 0, 0, 0}; tbl[1].tol = 0;
        tbl[2].name = "alternating"; tbl[2].xr = '{4, -4, 4, -4, 4, -4, 4, -4};
        tbl[2].er = '{0, 0, 0, 0, ALT, 0, 0, 0}; tbl[2].tol = 0;
        tbl[3].name = "cosine"; tbl[3].xr = '{64, 45, 0, -45, -64, -45, 0, 45};
        tbl[3].er = '{0, COSV, 0, 0, 0, 0, 0, COSV}; tbl[3].tol = 2;

        repeat (3) @(posedge clk);
        #1;
        check_idle8("reset");
        chk("reset_in_rdy16", int'(rdy16), 1);
        chk("reset_busy16", int'(busy16), 0);
        rstn = 1'b0;

        for (int t = 0; t < 4; t++) run_vec(t);

        // Backpressure at idx 3 with stray input pulses
        for (int k = 0; k < 8; k++) begin
            stim[k] = tbl[0].xr[k];
            e.idx = k; e.r = IMP; e.i = 0; e.tol = 0;
            q8.push_back(e);
        end
        send(1'b0, 8, 12);
        for (int w = 0; w < 50 && !(ov8 && idx8 == 3'd3); w++) begin @(posedge clk); #1; end
        ordy8 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            v8 = c[0];
            r8 = 9'd100;
            @(posedge clk); #1;
            chk("bp_out_vld", int'(ov8), 1);
            chk("bp_out_idx", int'(idx8), 3);
            chk("bp_out_r", int'($signed(or8)), IMP);
            chk("bp_out_i", int'($signed(oi8)), 0);
            chk("bp_in_rdy", int'(rdy8), 0);
        end
        v8 = 1'b0;
        ordy8 = 1'b1;
        wait_done(1'b0);
        run_vec(1);

        // Reset during stage 1 of COMPUTE aborts the frame
        for (int k = 0; k < 8; k++) stim[k] = 7 * k - 20;
        send(1'b0, 8, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", int'(busy8), 1);
        rstn = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b0;
        check_idle8("abort");
        run_vec(0);

        // 16-point engine: impulse, 32-cycle latency, index wrap back to LOAD
        for (int k = 0; k < 16; k++) begin
            stim[k] = (k == 0) ? 16 : 0;
            e.idx = k; e.r = IMP16; e.i = 0; e.tol = 0;
            q16.push_back(e);
        end
        send(1'b1, 16, 32);
        wait_done(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/fft_engine_n.md
Name: fft_engine_n

Overview:
- Parametrised successor to the fixed 8-point low-power DIT FFT: N = 2^LOG2N point radix-2 DIT engine, memory-based, one shared butterfly unit.
- Accepts complex samples serially with valid/ready handshake, stores them bit-reversed, runs LOG2N in-place stages, streams results in natural order.
- Sits between the sample front end and the spectrum consumer. Replaces the hard-wired stage muxes with an address generator and a twiddle ROM.

Parameters:
- WIDTH, 9, signed two's-complement width of data and twiddles.
- LOG2N, 3, log2 of transform size; legal range 3..6 (N = 8..64).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  synchronous, active-high reset (name kept per codebase convention; asserted = 1).
- in_vld  in  1  input sample valid.
- in_rdy  out  1  engine can accept a sample (high only in LOAD).
- in_r  in  WIDTH  input real part.
- in_i  in  WIDTH  input imaginary part.
- out_vld  out  1  output sample valid.
- out_rdy  in  1  consumer accepts output.
- out_r  out  WIDTH  output real part.
- out_i  out  WIDTH  output imaginary part.
- out_idx  out  LOG2N  frequency bin index of current output.
- busy  out  1  high in COMPUTE or UNLOAD.

Behaviour:
- Reset: state=LOAD, in_rdy=1, out_vld=0, busy=0, out_r/out_i/out_idx=0, counters=0. Memory contents undefined (not cleared).
- Reset mid-operation aborts the frame; the next frame starts from sample 0.
- Storage: N-entry complex flop array, combinational read, synchronous write.
- LOAD: each accepted sample (in_vld & in_rdy) is written to address bitrev(cnt); cnt increments.
  - Acceptance of sample N-1 moves state to COMPUTE on the same edge; in_rdy drops the next cycle.
- COMPUTE: exactly one butterfly per cycle, N/2 per stage, LOG2N stages, total LOG2N*N/2 cycles (12 for N=8).
  - Stage s (0..LOG2N-1), butterfly b: span=2^s; group = b>>s; j = b mod span; top = group*2^(s+1)+j; bot = top+span.
  - Twiddle index k = j*2^(LOG2N-1-s).
  - Both results are written back on the same edge.
- Butterfly: t = B*W (complex). Each product is full 2*WIDTH bits, then arithmetic right shift by WIDTH-2 (truncation).
  - A' = A+t, B' = A-t, truncated to WIDTH bits (wraps on overflow).
- Twiddle ROM: W_N^k = cos(2πk/N) - j·sin(2πk/N) for k=0..N/2-1, computed at elaboration.
  - Format: round(value·2^(WIDTH-2)), i.e. 1.0 = 128 for WIDTH=9; cos(π/4) = 91.
- UNLOAD: entered on the edge completing the last butterfly.
  - out_vld asserted from the next cycle; outputs address idx in natural order with out_idx = idx.
  - idx advances only on out_vld & out_rdy. out_vld is held with stable data while out_rdy=0.
  - Acceptance of idx N-1 moves state to LOAD: out_vld=0, in_rdy=1 the next cycle, busy=0.
- Latency: the last input accept edge E is followed by the first out_vld at edge E + LOG2N*N/2 (sampled high in the following cycle).
- No input overlap: in_vld during COMPUTE/UNLOAD is ignored (in_rdy=0, sample not consumed).
- Counter wrap: butterfly counter resets at each stage end; the stage counter terminates at LOG2N-1 (no wrap into stage LOG2N).

Optional Feature:
- FFT_STAGE_SCALE_EN defined: both butterfly outputs are arithmetically right-shifted by 1 before write-back, each stage. Results equal X[k]/N with truncation, and overflow is impossible for |input| < 2^(WIDTH-2).
- Undefined: no scaling; results are wrap-around modulo 2^WIDTH, matching the legacy 8-point block.

Test Plan:
- Impulse, N=8, WIDTH=9, unscaled: in_r = 16,0,0,0,0,0,0,0, in_i = 0 -> all 8 outputs 16+0j, out_idx 0..7; with FFT_STAGE_SCALE_EN -> all 2+0j.
- DC: 8 samples of 4+0j -> bin0 = 32+0j, bins 1..7 = 0+0j; first out_vld exactly 12 cycles after the last in accept edge.
- Alternating 4,-4,4,-4,... -> bin4 = 32+0j, others 0. Sample cos(πn/4)·64 quantised (64,45,0,-45,-64,-45,0,45) -> bins 1 and 7 ≈ 256 (±2 LSB truncation); with scale enabled -> ≈ 32.
- Backpressure: hold out_rdy=0 for 5 cycles at idx=3 -> out_vld stays 1, out_r/out_i/out_idx stable; in_vld pulses during UNLOAD are not consumed; in_rdy=0 until after idx 7 accept.
- Reset mid-COMPUTE (rstn=1 for one cycle at stage 1) -> next cycle in_rdy=1, out_vld=0, busy=0; a fresh impulse frame then yields the correct all-16 spectrum.
- LOG2N=4, N=16: impulse 16 at x0 -> 16 outputs of 16+0j; first out_vld 32 cycles after the last accept; out_idx wraps 15 -> LOAD.
